bcd_convert_seq: RTL

- Iterative (shift-add-3 / double-dabble) binary-to-BCD engine with start/busy/done handshake. It replaces the combinational converter on the calculator result path.
- Sits between the ALU result register and the 7-segment display driver.
- Converts one WIDTH-bit unsigned value into DIGITS packed BCD digits, one bit per clock, so the combinational adder chain is kept off the display timing path.

---
 rtl/bcd_convert_seq_if.sv | 29 ++
 rtl/bcd_convert_seq.sv | 134 +++++++++++++
 2 files changed

// File: rtl/bcd_convert_seq_if.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module  : bcd_convert_seq_if
// Purpose : Handshake/data bundle between the ALU result stage and the
//           iterative binary-to-BCD converter.
// Options : BCD_LEADING_ZERO_BLANK_EN adds the leading-zero blank mask.
// Rev     : 1.0 - initial release
// ============================================================================
interface bcd_convert_seq_if #(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5
);
  logic                  start;
  logic [WIDTH-1:0]      bin;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   bcd;
`ifdef BCD_LEADING_ZERO_BLANK_EN
  logic [DIGITS-1:0]     blank;

  modport master (output start, bin, input busy, done, bcd, blank);
  modport slave  (input start, bin, output busy, done, bcd, blank);
`else
  modport master (output start, bin, input busy, done, bcd);
  modport slave  (input start, bin, output busy, done, bcd);
`endif
endinterface
`default_nettype wire

// File: rtl/bcd_convert_seq.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module  : bcd_convert_seq
// Purpose : Iterative shift-add-3 (double-dabble) binary-to-BCD converter,
//           one input bit per clock, with start/busy/done handshake.
// Options : BCD_LEADING_ZERO_BLANK_EN enables the leading-zero blank mask.
// Rev     : 1.0 - initial release
// ============================================================================
module bcd_convert_seq #(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5
) (
  input  logic             clk,
  input  logic             rst,
  bcd_convert_seq_if.slave bus
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam int BCD_W = 4 * DIGITS;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [BCD_W-1:0] scratch_q, scratch_d;
  logic [BCD_W-1:0] bcd_q, bcd_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Scratch digits after the add-3 step and after the shift that follows it.
  logic [BCD_W-1:0] adjusted;
  logic [BCD_W-1:0] shifted;

  // Each digit >= 5 gets +3 before the shift so it carries correctly into the
  // next digit; a 4-bit add suffices because an adjusted digit never exceeds 12.
  for (genvar i = 0; i < DIGITS; i++) begin : g_adj
    assign adjusted[4*i +: 4] = (scratch_q[4*i +: 4] >= 4'd5) ?
                                (scratch_q[4*i +: 4] + 4'd3) :
                                scratch_q[4*i +: 4];
  end

  assign shifted = {adjusted[BCD_W-2:0], shreg_q[WIDTH-1]};

`ifdef BCD_LEADING_ZERO_BLANK_EN
  logic [DIGITS-1:0] blank_q, blank_d;
  logic [DIGITS-1:0] blank_next;
  logic [DIGITS:0]   zero_from;

  // zero_from[i] is set when digit i and every digit above it are zero.
  assign zero_from[DIGITS] = 1'b1;
  for (genvar i = 0; i < DIGITS; i++) begin : g_blank
    assign zero_from[i] = zero_from[i+1] & (shifted[4*i +: 4] == 4'd0);
  end

  // The units digit is never blanked so a zero result still shows "0".
  assign blank_next = {zero_from[DIGITS-1:1], 1'b0};
  assign bus.blank  = blank_q;
`endif

  assign bus.busy = (state_q != S_IDLE);
  assign bus.done = (state_q == S_DONE);
  assign bus.bcd  = bcd_q;

  // State and datapath registers; reset aborts any conversion in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      shreg_q   <= '0;
      scratch_q <= '0;
      cnt_q     <= '0;
      bcd_q     <= '0;
`ifdef BCD_LEADING_ZERO_BLANK_EN
      blank_q   <= '0;
`endif
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      scratch_q <= scratch_d;
      cnt_q     <= cnt_d;
      bcd_q     <= bcd_d;
`ifdef BCD_LEADING_ZERO_BLANK_EN
      blank_q   <= blank_d;
`endif
    end
  end

  // Next-state and datapath: capture on start, shift once per cycle, publish
  // the result on the last shift so it is visible during the done cycle.
  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    scratch_d = scratch_q;
    cnt_d     = cnt_q;
    bcd_d     = bcd_q;
`ifdef BCD_LEADING_ZERO_BLANK_EN
    blank_d   = blank_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          shreg_d   = bus.bin;
          scratch_d = '0;
          cnt_d     = CNT_W'(WIDTH);
          state_d   = S_SHIFT;
        end
      end
      S_SHIFT: begin
        scratch_d = shifted;
        shreg_d   = {shreg_q[WIDTH-2:0], 1'b0};
        cnt_d     = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = S_DONE;
          bcd_d   = shifted;
`ifdef BCD_LEADING_ZERO_BLANK_EN
          blank_d = blank_next;
`endif
        end
      end
      S_DONE: begin
        // A start seen here is dropped; it is not held over to IDLE.
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

endmodule
`default_nettype wire
